// File: rtl/screen_controller_pkg.sv
// Shared types and constants for the screen sequencer and its click detector.
package screen_controller_pkg;

  localparam int unsigned PIX_W    = 12;
  localparam int unsigned SCR_W    = 2;
  localparam int unsigned TIMING_W = 10;
  localparam int unsigned FRAME_W  = 10;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [SCR_W-1:0] {
    SCR_MENU  = 2'd0,
    SCR_GAME  = 2'd1,
    SCR_OVER  = 2'd2,
    SCR_BLANK = 2'd3
  } screen_t;

  localparam pixel_t BLACK = 12'h000;

  // Single-entry screen change request waiting for the next vblank.
  typedef struct packed {
    logic    valid;
    screen_t screen;
  } pend_t;

endpackage

// File: rtl/screen_controller_click_detector.sv
// Turns a raw button level plus hover flag into a one-cycle click:
// press and release must both happen over the button.
module click_detector
  import screen_controller_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic MOUSE_LEFT,
  input  logic hover,
  input  logic clear,
  output logic click
);

  logic left_q;
  logic left_prev;
  logic armed;
  logic rise_c;
  logic fall_c;

  assign rise_c = left_q & ~left_prev;
  assign fall_c = ~left_q & left_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      left_q    <= 1'b0;
      left_prev <= 1'b0;
      armed     <= 1'b0;
      click     <= 1'b0;
    end else begin
      left_q    <= MOUSE_LEFT;
      left_prev <= left_q;
      click     <= fall_c & armed & hover & ~clear;
      // Any release or screen commit disarms; a press over the button arms.
      if (clear || fall_c) begin
        armed <= 1'b0;
      end else if (rise_c && hover) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/screen_controller.sv
// MENU/GAME/OVER display sequencer: screen changes are queued and committed
// at the start of vertical blanking, and the matching pixel source is muxed out.
module screen_controller
  import screen_controller_pkg::*;
#(
  parameter int unsigned H_ACTIVE            = 640,
  parameter int unsigned V_ACTIVE            = 480,
  parameter int unsigned OVER_TIMEOUT_FRAMES = 600
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TIMING_W-1:0] h_cnt,
  input  logic [TIMING_W-1:0] v_cnt,
  input  logic                valid,
  input  logic                MOUSE_LEFT,
  input  logic                mouse_on_start_button,
  input  logic                mouse_on_return_button,
  input  logic                game_over,
  input  pixel_t              pixel_menu_in,
  input  pixel_t              pixel_game_in,
  input  pixel_t              pixel_over_in,
  output pixel_t              pixel_out,
  output logic [SCR_W-1:0]    screen,
  output logic                game_start,
  output logic                game_reset
);

  screen_t              scr_q, scr_nxt;
  pend_t                pend_q, pend_nxt;
  logic [FRAME_W-1:0]   frame_q, frame_nxt;
  pixel_t               pixel_nxt;
  logic                 game_start_nxt;
  logic                 game_reset_nxt;
  logic                 req_valid;
  screen_t              req_scr;
  logic                 boundary_c;
  logic                 commit_c;
  logic                 timeout_c;
  logic                 hover_c;
  logic                 click;

  assign boundary_c = (h_cnt == '0) && (v_cnt == TIMING_W'(V_ACTIVE));
  assign commit_c   = boundary_c && pend_q.valid;
  assign timeout_c  = (OVER_TIMEOUT_FRAMES != 0) &&
                      (frame_q >= FRAME_W'(OVER_TIMEOUT_FRAMES));
  assign hover_c    = ((scr_q == SCR_MENU) && mouse_on_start_button) ||
                      ((scr_q == SCR_OVER) && mouse_on_return_button);
  assign screen     = scr_q;

  click_detector u_click (
    .clk        (clk),
    .rst_n      (rst_n),
    .MOUSE_LEFT (MOUSE_LEFT),
    .hover      (hover_c),
    .clear      (commit_c),
    .click      (click)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scr_q      <= SCR_MENU;
      pend_q     <= '0;
      frame_q    <= '0;
      pixel_out  <= BLACK;
      game_start <= 1'b0;
      game_reset <= 1'b0;
    end else begin
      scr_q      <= scr_nxt;
      pend_q     <= pend_nxt;
      frame_q    <= frame_nxt;
      pixel_out  <= pixel_nxt;
      game_start <= game_start_nxt;
      game_reset <= game_reset_nxt;
    end
  end

  // Next state: raise requests, hold one pending, commit it at vblank.
  always_comb begin
    scr_nxt   = scr_q;
    pend_nxt  = pend_q;
    frame_nxt = frame_q;
    req_valid = 1'b0;
    req_scr   = scr_q;
    unique case (scr_q)
      SCR_MENU: if (click) begin
        req_valid = 1'b1;
        req_scr   = SCR_GAME;
      end
      SCR_GAME: if (game_over) begin
        req_valid = 1'b1;
        req_scr   = SCR_OVER;
      end
      SCR_OVER: if (click || timeout_c) begin
        req_valid = 1'b1;
        req_scr   = SCR_MENU;
      end
      default: ;
    endcase
    if (commit_c) begin
      scr_nxt        = pend_q.screen;
      pend_nxt.valid = 1'b0;
      frame_nxt      = '0;
    end else begin
      if (req_valid && !pend_q.valid) begin
        pend_nxt = '{valid: 1'b1, screen: req_scr};
      end
      if ((scr_q == SCR_OVER) && boundary_c && (frame_q != '1)) begin
        frame_nxt = frame_q + FRAME_W'(1);
      end
    end
  end

  // Output decode: commit pulses and the per-screen pixel mux.
  always_comb begin
    game_start_nxt = commit_c && (pend_q.screen == SCR_GAME);
    game_reset_nxt = commit_c && (pend_q.screen == SCR_MENU) && (scr_q == SCR_OVER);
    pixel_nxt      = BLACK;
    if (valid && (h_cnt < TIMING_W'(H_ACTIVE))) begin
      unique case (scr_q)
        SCR_MENU: pixel_nxt = pixel_menu_in;
        SCR_GAME: pixel_nxt = pixel_game_in;
        SCR_OVER: pixel_nxt = pixel_over_in;
        default:  pixel_nxt = BLACK;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_controller.sv
// Scoreboard bench for screen_controller on a shrunken VGA frame.
module tb_screen_controller;

  localparam int H_ACT   = 8;
  localparam int H_TOT   = 12;
  localparam int V_ACT   = 6;
  localparam int V_TOT   = 9;
  localparam int FRAME   = H_TOT * V_TOT;
  localparam logic [11:0] PIX_MENU = 12'hABC;
  localparam logic [11:0] PIX_GAME = 12'h123;
  localparam logic [11:0] PIX_OVER = 12'h456;

  typedef struct {
    int         bnd;
    logic [1:0] scr;
    logic       st;
    logic       rs;
  } ev_t;

  typedef struct {
    int          due;
    logic [11:0] pix;
  } px_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  h_cnt = 10'(H_TOT - 1);
  logic [9:0]  v_cnt = 10'(V_TOT - 1);
  logic        valid = 1'b0;
  logic        mouse_left = 1'b0;
  logic        on_start = 1'b0;
  logic        on_return = 1'b0;
  logic        game_over = 1'b0;
  logic [11:0] pixel_out;
  logic [1:0]  screen;
  logic        game_start;
  logic        game_reset;

  int  n_chk = 0;
  int  n_bad = 0;
  int  bnd_cnt = 0;
  int  cyc = 0;
  int  last_evt_bnd = 0;
  int  e0;
  logic [1:0] prev_scr = 2'd0;
  ev_t exp_q[$];
  px_t pix_q[$];

  screen_controller #(
    .H_ACTIVE            (H_ACT),
    .V_ACTIVE            (V_ACT),
    .OVER_TIMEOUT_FRAMES (3)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .h_cnt                  (h_cnt),
    .v_cnt                  (v_cnt),
    .valid                  (valid),
    .MOUSE_LEFT             (mouse_left),
    .mouse_on_start_button  (on_start),
    .mouse_on_return_button (on_return),
    .game_over              (game_over),
    .pixel_menu_in          (PIX_MENU),
    .pixel_game_in          (PIX_GAME),
    .pixel_over_in          (PIX_OVER),
    .pixel_out              (pixel_out),
    .screen                 (screen),
    .game_start             (game_start),
    .game_reset             (game_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // VGA timing model: counters advance just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (32'(h_cnt) == H_TOT - 1) begin
      h_cnt = 10'd0;
      v_cnt = (32'(v_cnt) == V_TOT - 1) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt = h_cnt + 10'd1;
    end
    valid = (32'(h_cnt) < H_ACT) && (32'(v_cnt) < V_ACT);
    if (h_cnt == 10'd0 && 32'(v_cnt) == V_ACT) bnd_cnt++;
  end

  // Monitor: pops expected pixels and screen-change events as they appear.
  always @(negedge clk) begin
    ev_t e;
    px_t p;
    cyc++;
    if (!rst_n) begin
      prev_scr = screen;
    end else begin
      if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
        p = pix_q.pop_front();
        check("pixel", 32'(pixel_out), 32'(p.pix));
      end
      if (screen !== prev_scr || game_start !== 1'b0 || game_reset !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("evt_unexpected", 32'({game_start, game_reset, screen}), 32'({2'b00, prev_scr}));
        end else begin
          e = exp_q.pop_front();
          check("evt_screen", 32'(screen), 32'(e.scr));
          check("evt_start", 32'(game_start), 32'(e.st));
          check("evt_reset", 32'(game_reset), 32'(e.rs));
          check("evt_boundary", 32'(bnd_cnt), 32'(e.bnd));
          last_evt_bnd = bnd_cnt;
        end
        prev_scr = screen;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pos(input int v, input int h);
    for (int i = 0; i < 2 * FRAME && !(32'(v_cnt) == v && 32'(h_cnt) == h); i++) tick();
    check("wait_pos", {16'(v_cnt), 16'(h_cnt)}, {16'(v), 16'(h)});
  endtask

  task automatic wait_bnd(input int n);
    for (int i = 0; i < 3 * FRAME && bnd_cnt < n; i++) tick();
    check("wait_bnd", 32'(bnd_cnt), 32'(n));
  endtask

  task automatic wait_evt();
    for (int i = 0; i < 6 * FRAME && exp_q.size() != 0; i++) tick();
    check("evt_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic expect_evt(input int bnd, input logic [1:0] scr, input logic st, input logic rs);
    ev_t e;
    e.bnd = bnd; e.scr = scr; e.st = st; e.rs = rs;
    exp_q.push_back(e);
  endtask

  // Pixel driven in this cycle appears at the second falling edge from now.
  task automatic pix_at(input int v, input int h, input logic [11:0] pix);
    px_t p;
    wait_pos(v, h);
    p.due = cyc + 2;
    p.pix = valid ? pix : 12'h000;
    pix_q.push_back(p);
    repeat (3) tick();
  endtask

  task automatic click_btn(input logic ret);
    if (ret) on_return = 1'b1; else on_start = 1'b1;
    repeat (2) tick();
    mouse_left = 1'b1;
    repeat (3) tick();
    mouse_left = 1'b0;
    repeat (3) tick();
    on_start = 1'b0;
    on_return = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with valid pixels present.
    repeat (5) tick();
    check("rst_screen", 32'(screen), 32'd0);
    check("rst_pixel", 32'(pixel_out), 32'd0);
    check("rst_start", 32'(game_start), 32'd0);
    check("rst_reset", 32'(game_reset), 32'd0);
    rst_n = 1'b1;
    pix_at(0, 6, PIX_MENU);

    // Drag-in and drag-out never click.
    wait_pos(1, 0);
    mouse_left = 1'b1;
    repeat (3) tick();
    on_start = 1'b1;
    repeat (2) tick();
    mouse_left = 1'b0;
    repeat (3) tick();
    on_start = 1'b0;
    repeat (2) tick();
    on_start = 1'b1;
    repeat (2) tick();
    mouse_left = 1'b1;
    repeat (3) tick();
    on_start = 1'b0;
    repeat (2) tick();
    mouse_left = 1'b0;
    repeat (3) tick();
    wait_pos(2, 0);
    check("drag_screen", 32'(screen), 32'd0);

    // Start click commits GAME at the next vblank.
    wait_pos(1, 0);
    click_btn(1'b0);
    expect_evt(bnd_cnt + 1, 2'd1, 1'b1, 1'b0);
    wait_evt();
    pix_at(2, 3, PIX_GAME);

    // game_over held three frames gives a single transition.
    wait_pos(1, 0);
    game_over = 1'b1;
    expect_evt(bnd_cnt + 1, 2'd2, 1'b0, 1'b0);
    repeat (3 * FRAME) tick();
    game_over = 1'b0;
    check("over_once", 32'(exp_q.size()), 32'd0);
    check("over_screen", 32'(screen), 32'd2);

    // Idle OVER returns to MENU on the fourth vblank.
    expect_evt(last_evt_bnd + 4, 2'd0, 1'b0, 1'b1);
    pix_at(2, 3, PIX_OVER);
    pix_at(V_ACT + 1, 2, PIX_OVER);
    wait_evt();
    pix_at(3, 1, PIX_MENU);

    // Return click in frame 1 of OVER commits at frame 2.
    wait_pos(1, 0);
    click_btn(1'b0);
    expect_evt(bnd_cnt + 1, 2'd1, 1'b1, 1'b0);
    wait_evt();
    wait_pos(1, 0);
    game_over = 1'b1;
    repeat (2) tick();
    game_over = 1'b0;
    expect_evt(bnd_cnt + 1, 2'd2, 1'b0, 1'b0);
    wait_evt();
    e0 = last_evt_bnd;
    wait_bnd(e0 + 1);
    wait_pos(1, 0);
    click_btn(1'b1);
    expect_evt(bnd_cnt + 1, 2'd0, 1'b0, 1'b1);
    check("ret_frame", 32'(bnd_cnt + 1), 32'(e0 + 2));
    wait_evt();

    // Request raised in the boundary cycle waits a whole frame.
    wait_pos(1, 0);
    click_btn(1'b0);
    expect_evt(bnd_cnt + 1, 2'd1, 1'b1, 1'b0);
    wait_evt();
    wait_pos(V_ACT, 0);
    game_over = 1'b1;
    expect_evt(bnd_cnt + 1, 2'd2, 1'b0, 1'b0);
    tick();
    game_over = 1'b0;
    wait_evt();
    wait_pos(1, 0);
    click_btn(1'b1);
    expect_evt(bnd_cnt + 1, 2'd0, 1'b0, 1'b1);
    wait_evt();

    // Reset with a request pending discards it.
    wait_pos(1, 0);
    click_btn(1'b0);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2 * FRAME) tick();
    check("rst_pend_screen", 32'(screen), 32'd0);
    check("pix_drain", 32'(pix_q.size()), 32'd0);
    check("evt_final", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
